// File: rtl/seq_detect_param.sv
// seq_detect_param: Mealy serial pattern detector with a runtime-loaded pattern
// of 1..MAX_LEN bits, overlapping or non-overlapping detection, and an optional
// saturating hit counter (enabled by defining SEQ_DET_HIT_CNT_EN).
// Reset defaults reproduce the classic 1011 overlapping detector.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1011,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               det,
    output logic [CNT_W-1:0]   hit_count
);

    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               ovl_reg;
    // Only the newest MAX_LEN-1 bits are kept: the oldest bit of a full
    // history can never fall inside the comparison window.
    logic [MAX_LEN-2:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [LEN_W-1:0]   fill_next;

    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] load_mask;
    logic [MAX_LEN-1:0] win;
    logic               match;

    // Clamp the requested length into 1..MAX_LEN before it is stored.
    always_comb begin
        len_clamp = cfg_len;
        if (cfg_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamp = LEN_W'(MAX_LEN);
        end
    end

    // Thermometer masks: bit gi set when gi lies inside the pattern length.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign mask[gi]      = (LEN_W'(gi) < len_reg);
            assign load_mask[gi] = (LEN_W'(gi) < len_clamp);
        end
    endgenerate

    assign win   = {hist_reg, din};
    assign match = ((win & mask) == pat_reg);

    // Detection happens in the same cycle as the last matching bit; the fill
    // check keeps stale or cleared history from contributing to a match.
    assign det = din_valid & ~cfg_load & ~rst
               & (fill_reg >= (len_reg - LEN_W'(1))) & match;

    // Fill count: restart after a non-overlapping hit, else saturating increment.
    always_comb begin
        fill_next = fill_reg;
        if (det && !ovl_reg) begin
            fill_next = '0;
        end else if (fill_reg != LEN_W'(MAX_LEN)) begin
            fill_next = fill_reg + LEN_W'(1);
        end
    end

    // Configuration and history state; a load wins over incoming data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg  <= DEF_PATTERN;
            len_reg  <= LEN_W'(DEF_LEN);
            ovl_reg  <= DEF_OVERLAP;
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (cfg_load) begin
            pat_reg  <= cfg_pattern & load_mask;
            len_reg  <= len_clamp;
            ovl_reg  <= cfg_overlap;
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (din_valid) begin
            hist_reg <= win[MAX_LEN-2:0];
            fill_reg <= fill_next;
        end
    end

`ifdef SEQ_DET_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Saturating hit counter; survives configuration loads, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (det && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign hit_count = cnt_reg;
`else
    assign hit_count = '0;
`endif

endmodule
